seq_ripple_adder: RTL



---
 rtl/seq_ripple_adder_if.sv | 25 ++
 rtl/seq_ripple_adder.sv | 106 ++++++++++
 2 files changed

// File: rtl/seq_ripple_adder_if.sv
// Operand/result bundle for seq_ripple_adder: start/busy/done handshake plus data.
interface seq_ripple_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/seq_ripple_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock, LSB digit first, registered carry.
// Results are held in registers and update only on the done edge.
module seq_ripple_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_ripple_adder_if.slave  bus
);
    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [DIGIT:0]   dig_full;
    logic [WIDTH-1:0] res_shift;
    logic             c_msb;

    assign dig_full  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + (DIGIT+1)'(carry_q);
    assign res_shift = WIDTH'({dig_full[DIGIT-1:0], res_q} >> DIGIT);
    // Carry into the top bit of this digit, recovered from its sum bit.
    assign c_msb     = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dig_full[DIGIT-1];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.cin ^ bus.sub;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dig_full[DIGIT];
                res_d   = res_shift;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = res_shift;
                    cout_d  = dig_full[DIGIT];
                    ovf_d   = c_msb ^ dig_full[DIGIT];
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy     = (state_q == StRun);
    assign bus.done     = done_q;
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule
